write_side_arbiter: RTL and testbench
=====================================

Name: write_side_arbiter

Overview:
Round-robin arbiter that shares the write (push/full) side of the async 2-entry FIFO among NUM_REQ requesters in the write clock domain. Each requester raises a request and gets a grant. The arbiter drives the single FIFO push and limits each owner to MAX_BURST consecutive accepted pushes before rotating. It sits between the requesters and the FIFO write interface receiver.

Parameters:
NUM_REQ, 4, number of requesters sharing the FIFO write port (2..16)
MAX_BURST, 2, maximum accepted pushes per grant tenure (1..255)
IDW, $clog2(NUM_REQ), derived localparam, width of gnt_id

Ports:
wclk  input  1  write-side clock; the only clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
req  input  NUM_REQ  per-requester request, level, held while data is pending
gnt  output  NUM_REQ  one-hot grant, zero when idle
gnt_id  output  IDW  index of current owner, valid when |gnt
push  output  1  FIFO push, to the write interface push
full  input  1  FIFO full, from the write interface full
beat  output  1  accepted transfer this cycle (equals push), for requester pop-of-source

Behaviour:
- Reset (reset==0, async): state=IDLE, owner=0, last=NUM_REQ-1, cnt=0. gnt=0, gnt_id=0, push=0, beat=0 immediately, with no clock edge needed.
- States: IDLE, BURST. Registers: state, owner, last, cnt (width to hold MAX_BURST-1).
- gnt[i] = (state==BURST) && owner==i. gnt_id = owner. Both are registered-derived and glitch-free.
- push = beat = (state==BURST) && req[owner] && !full. This is the only combinational path. push is never asserted while full==1.
- IDLE: if |req, owner<=rr_pick(req, last), cnt<=0, state<=BURST. The first grant appears 1 cycle after req rises, and no push happens in the IDLE cycle. If req==0, stay in IDLE.
- BURST, push==1 and cnt<MAX_BURST-1: cnt<=cnt+1, hold owner.
- BURST, release when push==1 && cnt==MAX_BURST-1, or when req[owner]==0:
  - last<=owner.
  - If |req: owner<=rr_pick(req, owner), cnt<=0, stay in BURST. Handoff is back-to-back with no idle cycle. If the old owner is the only requester it is re-granted with cnt cleared.
  - Else state<=IDLE.
- BURST, full==1 && req[owner]==1: hold everything. The owner keeps its grant and cnt is frozen, so there is no rotation on backpressure.
- Precedence: the req[owner]==0 release takes priority over full.
- rr_pick(req, ptr): first set bit scanning from ptr+1 upward, wrapping modulo NUM_REQ. Inputs are never all-zero when its result is used.
- Requester contract: req may only drop after a beat or while not granted. A beat with gnt[i]==1 means one item from requester i is accepted.
- Throughput: with continuous requests and full==0, push==1 every cycle after the first grant.

Decomposition:
- Package write_arb_pkg:
  - arb_state_e enum {IDLE, BURST}
  - default constants NUM_REQ_DEF=4, MAX_BURST_DEF=2
  - function clog2_min1
- Sub-module rr_pick: purely combinational rotating-priority picker.
  - Parameters: NUM_REQ.
  - Ports: req[NUM_REQ], ptr[IDW], sel[IDW], any.
  - Instantiated once.
- The top holds the FSM, counters and output logic.

Test Plan:
1. Hold reset=0 with req=4'b1111 → gnt=0, push=0, gnt_id=0. Release reset with req=0 → remains IDLE, push=0 for 10 cycles.
2. req=4'b0010, full=0, MAX_BURST=2 → cycle 1 gnt=4'b0010, gnt_id=1. push=1 every cycle from cycle 1 on, with re-grant to 1 every 2 beats and no gap.
3. req=4'b1111 constant, full=0 → gnt_id sequence 0,0,1,1,2,2,3,3,0,... and push=1 every cycle after the first grant.
4. Requester 1 owns with cnt=1 beat done, then full=1 for 3 cycles → push=0, gnt=4'b0010 held. When full drops: one more beat, then handoff to the next requester.
5. Owner 2 drops req after 1 beat while req[3]=1 → that cycle push=0, next cycle gnt=4'b1000, gnt_id=3.
6. Async reset asserted mid-burst between clock edges → push and gnt go to 0 without a wclk edge. After release with req=4'b1111 → first grant goes to requester 0.

Source files
------------

// File: rtl/write_arb_pkg.sv
// Shared types and constants for the write-side FIFO arbiter.
package write_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 2;

    // Like $clog2, but never returns less than 1, so it is always a legal vector width.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/write_side_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first set request strictly after ptr, wrapping around.
module rr_pick
    import write_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDW = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     sel,
    output logic               any
);

    int idx;

    // The scan starts at ptr+1, so ptr itself has the lowest priority.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/write_side_arbiter.sv
// Round-robin owner of the shared FIFO push port. Each owner keeps the port
// for at most MAX_BURST accepted pushes before the grant rotates.
module write_side_arbiter
    import write_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    localparam int IDW = clog2_min1(NUM_REQ)
) (
    input  logic               wclk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               push,
    input  logic               full,
    output logic               beat,
    output arb_state_e         state_dbg
);

    // Handshake: push acts as valid and !full as ready; an item moves (beat)
    // in exactly the cycles where push is high, and push is never high while full is.

    localparam int CNTW = clog2_min1(MAX_BURST);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]      state;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  last;
    logic [CNTW-1:0] cnt;

    logic [IDW-1:0] pick_ptr;
    logic [IDW-1:0] pick_sel;
    logic           any_req;
    logic           push_c;
    logic           release_c;

    // From IDLE, rotate relative to the previous owner; in BURST, relative to the current one.
    assign pick_ptr = (state == S_IDLE) ? last : owner;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req(req),
        .ptr(pick_ptr),
        .sel(pick_sel),
        .any(any_req)
    );

    assign push_c    = (state == S_BURST) && req[owner] && !full;
    assign release_c = (state == S_BURST) &&
                       (!req[owner] || (push_c && (cnt == CNT_LAST)));

    always_ff @(posedge wclk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            owner <= '0;
            last  <= IDW'(NUM_REQ - 1);
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner <= pick_sel;
                        cnt   <= '0;
                        state <= S_BURST;
                    end
                end
                default: begin
                    // A dropped request wins over backpressure: release first, then check full.
                    if (release_c) begin
                        last <= owner;
                        if (any_req) begin
                            owner <= pick_sel;
                            cnt   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (push_c) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (state == S_BURST) begin
            gnt[owner] = 1'b1;
        end
    end

    assign gnt_id    = owner;
    assign push      = push_c;
    assign beat      = push_c;
    assign state_dbg = arb_state_e'(state);

endmodule

// File: tb/tb_write_side_arbiter.sv
// Randomized and directed bench for write_side_arbiter with a tenure-level reference model.
module tb_write_side_arbiter;
    import write_arb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 2;
    localparam int IDW       = 2;
    localparam int GW        = 1 + IDW + NUM_REQ + 1;

    logic               wclk  = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_REQ-1:0] req   = '0;
    logic               full  = 1'b0;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               push;
    logic               beat;
    arb_state_e         state_dbg;

    write_side_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .wclk(wclk),
        .reset(reset),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .push(push),
        .full(full),
        .beat(beat),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Scoreboard queues: per-cycle record {busy, id, gnt, push}, and per-beat owner id
    logic [GW-1:0]  exp_q[$];
    logic [IDW-1:0] beat_q[$];

    // Reference model: who holds the port, who held it last, beats in this tenure
    bit m_busy;
    int m_owner;
    int m_last;
    int m_beats;
    int pending[NUM_REQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int next_after(input int ptr, input logic [NUM_REQ-1:0] r);
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (r[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NUM_REQ - 1;
        m_beats = 0;
        for (int i = 0; i < NUM_REQ; i++) pending[i] = 0;
    endtask

    task automatic model_step(input logic [NUM_REQ-1:0] r, input bit mp);
        if (!m_busy) begin
            if (r != 0) begin
                m_owner = next_after(m_last, r);
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else if (!r[m_owner] || (mp && (m_beats + 1 == MAX_BURST))) begin
            m_last = m_owner;
            if (r != 0) begin
                m_owner = next_after(m_owner, r);
                m_beats = 0;
            end else begin
                m_busy = 1'b0;
            end
        end else if (mp) begin
            m_beats++;
        end
    endtask

    // Driver: mode 0 draws requests from random per-requester backlogs; mode 1 holds fixed_req.
    task automatic run_cycles(input int n, input int mode, input logic [NUM_REQ-1:0] fixed_req,
                              input int arr_pct, input int full_pct);
        logic [NUM_REQ-1:0] cur;
        logic [NUM_REQ-1:0] eg;
        bit mp;
        for (int k = 0; k < n; k++) begin
            @(posedge wclk);
            #1;
            cyc++;
            cur = fixed_req;
            if (mode == 0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (pending[i] == 0 && $urandom_range(0, 99) < arr_pct)
                        pending[i] = $urandom_range(1, 5);
                    cur[i] = (pending[i] > 0);
                end
            end
            full = ($urandom_range(0, 99) < full_pct);
            req  = cur;
            mp   = m_busy && cur[m_owner] && !full;
            eg   = '0;
            if (m_busy) eg[m_owner] = 1'b1;
            exp_q.push_back({m_busy, IDW'(m_owner), eg, mp});
            if (mp) begin
                beat_q.push_back(IDW'(m_owner));
                if (mode == 0) pending[m_owner]--;
            end
            model_step(cur, mp);
            mon_en = 1'b1;
        end
        @(negedge wclk);
        #1;
        mon_en = 1'b0;
        check("leftover_cycles", exp_q.size(), 0);
        check("leftover_beats", beat_q.size(), 0);
        exp_q.delete();
        beat_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        full  = 1'b0;
        model_reset();
        @(posedge wclk);
        @(negedge wclk);
        reset = 1'b1;
    endtask

    // Monitor: consumes one expected record per sampled cycle, and one beat record per DUT push.
    always @(negedge wclk) begin
        logic [GW-1:0] e;
        logic [IDW-1:0] b;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL exp_q_empty cyc=%0d act=push:%0b exp=record", cyc, push);
            end else begin
                e = exp_q.pop_front();
                check("gnt", gnt, e[NUM_REQ:1]);
                check("push", push, e[0]);
                check("beat", beat, e[0]);
                check("state", state_dbg, e[GW-1] ? BURST : IDLE);
                if (e[GW-1]) check("gnt_id", gnt_id, e[GW-2:NUM_REQ+1]);
            end
            if (push) begin
                if (beat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_q_empty cyc=%0d act=beat id %0d exp=no beat", cyc, gnt_id);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_owner", gnt_id, b);
                end
            end
        end
    end

    initial begin
        model_reset();
        reset = 1'b0;
        req   = '1;
        full  = 1'b0;
        #12;
        check("rst_gnt", gnt, 0);
        check("rst_push", push, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_beat", beat, 0);
        @(posedge wclk);
        #1;
        check("rst_gnt_edge", gnt, 0);
        check("rst_push_edge", push, 0);
        req = '0;
        @(negedge wclk);
        reset = 1'b1;

        run_cycles(10, 1, 4'b0000, 0, 0);
        run_cycles(12, 1, 4'b0010, 0, 0);
        run_cycles(20, 1, 4'b1111, 0, 0);
        run_cycles(40, 1, 4'b1111, 0, 40);

        // Asynchronous reset in the middle of a burst, between clock edges
        full = 1'b0;
        #1;
        check("pre_reset_push", push, 1);
        reset = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_push", push, 0);
        check("async_beat", beat, 0);
        check("async_gnt_id", gnt_id, 0);
        req = '0;
        model_reset();
        @(posedge wclk);
        @(negedge wclk);
        reset = 1'b1;
        run_cycles(12, 1, 4'b1111, 0, 0);

        do_reset();
        run_cycles(1500, 0, '0, 40, 30);
        run_cycles(1000, 0, '0, 70, 10);
        run_cycles(300, 0, '0, 15, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
